mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-only data memory.
- Takes LB/LBU/LH/LHU/LW/SB/SH/SW requests from the EX/MEM pipeline and drives the memory's op/address/write-data/read-data interface.
- The memory reads combinationally and writes whole words on the clock edge. This block therefore performs sub-word extraction and sign/zero extension on loads, read-modify-write for SB/SH, and alignment checking.
- Results go back to the pipeline through a one-deep valid/ready handshake.

Parameters:
- OP_LB, 6'h20, byte load opcode (sign-extend)
- OP_LH, 6'h21, halfword load opcode (sign-extend)
- OP_LW, 6'h23, word load opcode
- OP_LBU, 6'h24, byte load opcode (zero-extend)
- OP_LHU, 6'h25, halfword load opcode (zero-extend)
- OP_SB, 6'h28, byte store opcode
- OP_SH, 6'h29, halfword store opcode
- OP_SW, 6'h2B, word store opcode
- OP_NOP, 6'h00, opcode driven to memory when no access is made

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_op  in  6  request opcode
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for SB/SH
- req_ready  out  1  unit can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: request completed
- resp_rdata  out  32  extended load result; held between responses
- resp_misalign  out  1  qualifies resp_valid: request was misaligned and no memory access was made
- dmem_op  out  6  opcode to data memory (OP_LW, OP_SW or OP_NOP)
- dmem_addr  out  32  word-aligned byte address to memory ({addr[31:2],2'b00})
- dmem_wdata  out  32  full word to write
- dmem_rdata  in  32  combinational read word from memory

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_misalign=0, resp_rdata=0.
  - Internal address/merge registers cleared.
  - dmem_op=OP_NOP, so no write can occur during reset.
- Byte order is little-endian:
  - byte k of a word is bits [8k+7:8k];
  - halfword at addr[1]=h is bits [16h+15:16h].
- States: IDLE, MERGE_WR.
- req_ready = (state==IDLE). A request is accepted on a clock edge where req_valid & req_ready.
- Alignment rule:
  - LH/LHU/SH are misaligned if addr[0]=1.
  - LW/SW are misaligned if addr[1:0]!=0.
  - Misaligned requests: dmem_op=OP_NOP; next cycle resp_valid=1 and resp_misalign=1; resp_rdata unchanged.
- Loads (IDLE, accept cycle):
  - dmem_op=OP_LW, dmem_addr from req_addr.
  - The selected byte/halfword/word of dmem_rdata is extended per opcode and registered into resp_rdata.
  - resp_valid=1 the following cycle. Latency 1; a new request can be accepted every cycle.
- SW (IDLE, accept cycle): dmem_op=OP_SW, dmem_wdata=req_wdata; memory is written at that edge; resp_valid next cycle. resp_rdata unchanged.
- SB/SH, cycle 0 (IDLE, accept):
  - dmem_op=OP_LW.
  - Merged word is registered: dmem_rdata with the target lane replaced by req_wdata[7:0] or [15:0].
  - Aligned address is registered; go to MERGE_WR.
- SB/SH, cycle 1 (MERGE_WR):
  - dmem_op=OP_SW, dmem_addr=registered address, dmem_wdata=merged word; req_ready=0.
  - Return to IDLE; resp_valid=1 in cycle 2.
- Any other opcode with req_valid=1: no access; resp_valid=1 next cycle; resp_misalign=0.
- In IDLE with no request: dmem_op=OP_NOP.
- resp_valid is a single-cycle pulse. The pipeline must consume it; there is no response back-pressure.
- Reset asserted in MERGE_WR aborts the store; memory is left with its pre-request contents; no resp_valid.
- dmem_wdata is 0 whenever dmem_op!=OP_SW.

Test Plan:
1. Preload word @0x10=0x8899AABB. LB 0x13 -> resp_rdata=0xFFFFFF88. LBU 0x10 -> 0x000000BB. LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. Each resp_valid one cycle after accept; four back-to-back accepts with req_ready held 1.
2. SB 0x11, wdata 0x123456CC -> dmem_op=OP_LW in cycle 0, OP_SW with wdata 0x8899CCBB in cycle 1, req_ready=0 in cycle 1, resp_valid in cycle 2. A following LW 0x10 returns 0x8899CCBB.
3. SH 0x12, wdata 0x00007777 -> word becomes 0x7777AABB. A request held on req_valid during MERGE_WR is accepted only in the next IDLE cycle.
4. LH 0x11, SW 0x16, LW 0x12 -> each gives resp_valid=1 with resp_misalign=1; dmem_op stays OP_NOP; memory and resp_rdata unchanged.
5. SW 0x20, wdata 0xDEADBEEF, then LW 0x20 next cycle -> 0xDEADBEEF; resp_misalign=0 throughout.
6. SB 0x10 accepted, rst_n pulled low mid-cycle in MERGE_WR -> outputs cleared immediately; word @0x10 still 0x8899AABB; no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit in front of a word-only, combinational-read data memory.
// Performs sub-word load extraction/extension, read-modify-write for SB/SH and alignment checks.
module mem_lsu #(
  parameter logic [5:0] OP_LB  = 6'h20,
  parameter logic [5:0] OP_LH  = 6'h21,
  parameter logic [5:0] OP_LW  = 6'h23,
  parameter logic [5:0] OP_LBU = 6'h24,
  parameter logic [5:0] OP_LHU = 6'h25,
  parameter logic [5:0] OP_SB  = 6'h28,
  parameter logic [5:0] OP_SH  = 6'h29,
  parameter logic [5:0] OP_SW  = 6'h2B,
  parameter logic [5:0] OP_NOP = 6'h00
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic [5:0]  dmem_op,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, MERGE_WR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic is_load, is_sw, is_sub_st, misalign;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h000000, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0000, h};
      default: load_extract = word;
    endcase
  endfunction

  // Replace the addressed byte or halfword lane of the current word with store data.
  function automatic logic [31:0] store_merge(input logic is_half, input logic [1:0] off,
                                              input logic [31:0] word, input logic [31:0] wdata);
    store_merge = word;
    if (is_half) begin
      if (off[1]) store_merge[31:16] = wdata[15:0];
      else        store_merge[15:0]  = wdata[15:0];
    end else begin
      case (off)
        2'd0:    store_merge[7:0]   = wdata[7:0];
        2'd1:    store_merge[15:8]  = wdata[7:0];
        2'd2:    store_merge[23:16] = wdata[7:0];
        2'd3:    store_merge[31:24] = wdata[7:0];
        default: store_merge = word;
      endcase
    end
  endfunction

  assign is_load   = req_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  assign is_sw     = (req_op == OP_SW);
  assign is_sub_st = (req_op == OP_SB) || (req_op == OP_SH);
  assign misalign  = ((req_op inside {OP_LH, OP_LHU, OP_SH}) && req_addr[0]) ||
                     ((req_op inside {OP_LW, OP_SW}) && (req_addr[1:0] != 2'b00));

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = valid_q;
  assign resp_misalign = mis_q;
  assign resp_rdata    = rdata_q;

  // Next-state, response and memory-interface decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    mis_d      = 1'b0;
    dmem_op    = OP_NOP;
    dmem_addr  = {req_addr[31:2], 2'b00};
    dmem_wdata = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          valid_d = 1'b1;
          if (misalign) begin
            mis_d = 1'b1;
          end else if (is_load) begin
            dmem_op = OP_LW;
            rdata_d = load_extract(req_op, req_addr[1:0], dmem_rdata);
          end else if (is_sw) begin
            dmem_op    = OP_SW;
            dmem_wdata = req_wdata;
          end else if (is_sub_st) begin
            // Response is deferred until the merged word has been written back.
            dmem_op = OP_LW;
            valid_d = 1'b0;
            merge_d = store_merge(req_op == OP_SH, req_addr[1:0], dmem_rdata, req_wdata);
            addr_d  = {req_addr[31:2], 2'b00};
            state_d = MERGE_WR;
          end else begin
            mis_d = 1'b0;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      MERGE_WR: begin
        dmem_op    = OP_SW;
        dmem_addr  = addr_q;
        dmem_wdata = merge_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered response; reset drops MERGE_WR so no write can follow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      merge_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed stimulus with a response scoreboard for mem_lsu.
module tb_mem_lsu;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_NOP = 6'h00;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_misalign;
  logic [31:0] resp_rdata;
  logic [5:0]  dmem_op;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  logic [31:0] mem [0:63];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_wa = 6'd0;
  logic [31:0] tb_wd = 32'h0;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
    int          due;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int waited;

  always #5 clock = ~clock;

  mem_lsu dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .dmem_op(dmem_op), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  // Word memory model: combinational read, whole-word write on the clock edge.
  assign dmem_rdata = mem[dmem_addr[7:2]];
  always @(posedge clock) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (dmem_op == OP_SW) mem[dmem_addr[7:2]] <= dmem_wdata;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clock) begin
    if (rst_n) begin
      if (dmem_op != OP_SW) chk("wdata_zero_when_not_sw", dmem_wdata, 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL resp_missing: no response by cycle %0d, expected at %0d", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp_spurious: resp_valid at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp_misalign", {31'b0, resp_misalign}, {31'b0, e.mis});
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_latency_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    tb_we = 1'b1; tb_wa = idx; tb_wd = data;
    @(posedge clock); #1;
    tb_we = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; req_op = OP_NOP; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Present one request (called at posedge+1), wait bounded for acceptance, queue its response.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [5:0] exp_op, input logic exp_mis, input logic [31:0] exp_rd,
                       input int lat, input bit push, output int w);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 4) begin @(posedge clock); #1; w++; end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: op %h never accepted, expected acceptance", op);
      req_valid = 1'b0;
      return;
    end
    #3;
    chk("accept_dmem_op", {26'b0, dmem_op}, {26'b0, exp_op});
    if (push) exp_q.push_back('{exp_mis, exp_rd, cyc + lat});
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = OP_NOP; req_addr = 32'h0; req_wdata = 32'h0;
    #2;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_misalign", {31'b0, resp_misalign}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_dmem_op", {26'b0, dmem_op}, {26'b0, OP_NOP});
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    preload(6'd4, 32'h8899AABB);
    preload(6'd5, 32'h01020304);
    preload(6'd8, 32'h00000000);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back sub-word loads
    issue(OP_LB,  32'h13, 32'h0, OP_LW, 1'b0, 32'hFFFFFF88, 1, 1'b1, waited);
    chk("t1_lb_ready", waited, 0);
    issue(OP_LBU, 32'h10, 32'h0, OP_LW, 1'b0, 32'h000000BB, 1, 1'b1, waited);
    chk("t1_lbu_ready", waited, 0);
    issue(OP_LH,  32'h12, 32'h0, OP_LW, 1'b0, 32'hFFFF8899, 1, 1'b1, waited);
    chk("t1_lh_ready", waited, 0);
    issue(OP_LHU, 32'h10, 32'h0, OP_LW, 1'b0, 32'h0000AABB, 1, 1'b1, waited);
    chk("t1_lhu_ready", waited, 0);

    // SB read-modify-write, then read back
    issue(OP_SB, 32'h11, 32'h123456CC, OP_LW, 1'b0, 32'h0000AABB, 2, 1'b1, waited);
    #3;
    chk("t2_merge_op", {26'b0, dmem_op}, {26'b0, OP_SW});
    chk("t2_merge_wdata", dmem_wdata, 32'h8899CCBB);
    chk("t2_merge_addr", dmem_addr, 32'h10);
    chk("t2_merge_ready", {31'b0, req_ready}, 32'h0);
    #2; @(posedge clock); #1;
    issue(OP_LW, 32'h10, 32'h0, OP_LW, 1'b0, 32'h8899CCBB, 1, 1'b1, waited);
    idle(1);
    preload(6'd4, 32'h8899AABB);

    // SH with a request held through MERGE_WR
    issue(OP_SH, 32'h12, 32'h00007777, OP_LW, 1'b0, 32'h8899CCBB, 2, 1'b1, waited);
    chk("t3_merge_wdata", dmem_wdata, 32'h7777AABB);
    issue(OP_LW, 32'h10, 32'h0, OP_LW, 1'b0, 32'h7777AABB, 1, 1'b1, waited);
    chk("t3_held_wait", waited, 1);

    // Misaligned requests and an unknown opcode
    issue(OP_LH, 32'h11, 32'h0, OP_NOP, 1'b1, 32'h7777AABB, 1, 1'b1, waited);
    issue(OP_SW, 32'h16, 32'hCAFEF00D, OP_NOP, 1'b1, 32'h7777AABB, 1, 1'b1, waited);
    issue(OP_LW, 32'h12, 32'h0, OP_NOP, 1'b1, 32'h7777AABB, 1, 1'b1, waited);
    issue(6'h3F, 32'h10, 32'h0, OP_NOP, 1'b0, 32'h7777AABB, 1, 1'b1, waited);
    idle(1);
    chk("t4_mem_word4", mem[4], 32'h7777AABB);
    chk("t4_mem_word5", mem[5], 32'h01020304);

    // SW then LW of the same word
    issue(OP_SW, 32'h20, 32'hDEADBEEF, OP_SW, 1'b0, 32'h7777AABB, 1, 1'b1, waited);
    issue(OP_LW, 32'h20, 32'h0, OP_LW, 1'b0, 32'hDEADBEEF, 1, 1'b1, waited);
    idle(1);
    chk("t5_mem_word8", mem[8], 32'hDEADBEEF);

    // Reset during MERGE_WR aborts the store
    preload(6'd4, 32'h8899AABB);
    issue(OP_SB, 32'h10, 32'h00000055, OP_LW, 1'b0, 32'h0, 2, 1'b0, waited);
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_dmem_op", {26'b0, dmem_op}, {26'b0, OP_NOP});
    chk("t6_rst_dmem_wdata", dmem_wdata, 32'h0);
    chk("t6_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("t6_rst_resp_rdata", resp_rdata, 32'h0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    idle(2);
    chk("t6_mem_word4", mem[4], 32'h8899AABB);
    chk("t6_ready_after", {31'b0, req_ready}, 32'h1);

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
